// File: rtl/ethermac_tx_framer.sv
// ethermac_tx_framer
// Transmit framer for the Ethernet MAC. A host writes one frame into the
// internal byte buffer and then requests transmission. The framer emits the
// preamble, SFD, payload (with optional tag substitution), zero padding up to
// MIN_LEN and a CRC-32 FCS computed on the fly. It then holds off the next
// frame until the interframe gap has elapsed.
//
// Ports
//   i_clk      clock
//   i_rst      synchronous active-high reset
//   i_wr_en    buffer byte write strobe (ignored while o_busy)
//   i_wr_addr  buffer byte address
//   i_wr_data  buffer write data
//   i_send     one-cycle transmit request
//   i_length   payload length in bytes excluding FCS, sampled with i_send
//   i_tag      2-bit tag value, sampled with i_send
//   o_txd      PHY transmit data, DATA_W bits (4 = MII nibbles, 8 = GMII bytes)
//   o_tx_en    PHY transmit enable
//   o_busy     request accepted and frame or interframe gap still in progress
//   o_done     pulse on the last FCS beat
//   o_err      pulse one cycle after a rejected request
module ethermac_tx_framer #(
  parameter int DATA_W     = 4,
  parameter int BUF_DEPTH  = 1024,
  parameter int MIN_LEN    = 60,
  parameter int PRE_BYTES  = 7,
  parameter int IFG_CYCLES = 24,
  parameter int TAG_EN     = 1,
  parameter int TAG_OFFSET = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_wr_en,
  input  logic [$clog2(BUF_DEPTH)-1:0]   i_wr_addr,
  input  logic [7:0]                     i_wr_data,
  input  logic                           i_send,
  input  logic [$clog2(BUF_DEPTH+1)-1:0] i_length,
  input  logic [1:0]                     i_tag,
  output logic [DATA_W-1:0]              o_txd,
  output logic                           o_tx_en,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_err
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int LW = $clog2(BUF_DEPTH + 1);
  localparam int PW = $clog2(MIN_LEN + 1);
  // Byte counter must reach both the longest payload and the padded length.
  localparam int CW = (LW > PW) ? LW : PW;
  localparam int GW = $clog2(IFG_CYCLES + 2);
  localparam logic [GW-1:0] IFG_C = GW'(IFG_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IFG_WAIT,
    S_PREAMBLE,
    S_SFD,
    S_DATA,
    S_PAD,
    S_FCS
  } state_t;

  // One byte of reflected CRC-32 (poly 0xEDB88320), LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  logic [7:0]        r_mem [BUF_DEPTH];
  logic [7:0]        r_rd_data;
  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_beat;
  logic [LW-1:0]     r_len;
  logic [1:0]        r_tag;
  logic [31:0]       r_crc;
  logic [GW-1:0]     r_gap;

  logic              w_len_ok;
  logic              w_accept;
  logic              w_emit;
  logic              w_last_beat;
  logic [CW-1:0]     w_len_c;
  logic              w_data_end;
  logic              w_pad_end;
  logic              w_pad_need;
  logic              w_tag_hit;
  logic [7:0]        w_byte;
  logic [DATA_W-1:0] w_beat;
  logic [AW-1:0]     w_rd_addr;

  assign w_len_ok    = (i_length != '0) && (i_length <= LW'(BUF_DEPTH));
  assign w_accept    = i_send && !o_busy && w_len_ok;
  assign w_emit      = (r_state == S_PREAMBLE) || (r_state == S_SFD) ||
                       (r_state == S_DATA) || (r_state == S_PAD) ||
                       (r_state == S_FCS);
  // In nibble mode a byte spans two beats; r_beat marks the high nibble.
  assign w_last_beat = (DATA_W == 8) ? 1'b1 : r_beat;
  assign w_len_c     = CW'(r_len);
  assign w_data_end  = (r_cnt == (w_len_c - CW'(1)));
  assign w_pad_end   = (r_cnt == CW'(MIN_LEN - 1));
  assign w_pad_need  = (w_len_c < CW'(MIN_LEN));
  // In DATA the count is always below the length, so an index match is enough.
  assign w_tag_hit   = (TAG_EN != 0) && (TAG_OFFSET < BUF_DEPTH) &&
                       (r_cnt == CW'(TAG_OFFSET));

  always_comb begin
    w_byte = 8'h00;
    case (r_state)
      S_PREAMBLE: w_byte = 8'h55;
      S_SFD:      w_byte = 8'hD5;
      S_DATA:     w_byte = w_tag_hit ? {r_rd_data[7:2], r_tag} : r_rd_data;
      S_PAD:      w_byte = 8'h00;
      S_FCS: begin
        case (r_cnt[1:0])
          2'd0:    w_byte = ~r_crc[7:0];
          2'd1:    w_byte = ~r_crc[15:8];
          2'd2:    w_byte = ~r_crc[23:16];
          default: w_byte = ~r_crc[31:24];
        endcase
      end
      default:    w_byte = 8'h00;
    endcase
  end

  // Read address leads the emitted byte by one cycle. Outside DATA it rests
  // at 0, which prefetches the first payload byte while the SFD goes out.
  always_comb begin
    w_rd_addr = '0;
    if (r_state == S_DATA) begin
      w_rd_addr = AW'(r_cnt) + AW'(w_last_beat);
    end
  end

  generate
    if (DATA_W == 8) begin : g_byte
      assign w_beat = w_byte[DATA_W-1:0];
    end else begin : g_nibble
      assign w_beat = r_beat ? w_byte[7:4] : w_byte[3:0];
    end
  endgenerate

  // Frame buffer: synchronous write port, registered read port.
  always_ff @(posedge i_clk) begin
    if (i_wr_en && !o_busy) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    r_rd_data <= r_mem[w_rd_addr];
  end

  // Control FSM with registered PHY outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_beat  <= 1'b0;
      r_gap   <= IFG_C;
      o_txd   <= '0;
      o_tx_en <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= i_send && !w_accept;

      // Gap restarts on the edge o_tx_en falls, then saturates.
      if (o_tx_en && !w_emit) begin
        r_gap <= '0;
      end else if (r_gap != IFG_C) begin
        r_gap <= r_gap + GW'(1);
      end

      if (w_emit) begin
        o_tx_en <= 1'b1;
        o_txd   <= w_beat;
        r_beat  <= !w_last_beat;
      end else begin
        o_tx_en <= 1'b0;
        o_txd   <= '0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_IFG_WAIT;
            r_len   <= i_length;
            r_tag   <= i_tag;
            o_busy  <= 1'b1;
          end else if (o_busy && !o_tx_en && (r_gap == IFG_C)) begin
            o_busy <= 1'b0;
          end
        end
        S_IFG_WAIT: begin
          if (r_gap == IFG_C) begin
            r_state <= (PRE_BYTES == 0) ? S_SFD : S_PREAMBLE;
            r_cnt   <= '0;
            r_beat  <= 1'b0;
          end
        end
        S_PREAMBLE: begin
          if (w_last_beat) begin
            if (r_cnt == CW'(PRE_BYTES - 1)) begin
              r_state <= S_SFD;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_SFD: begin
          if (w_last_beat) begin
            r_state <= S_DATA;
            r_cnt   <= '0;
            r_crc   <= 32'hFFFF_FFFF;
          end
        end
        S_DATA: begin
          if (w_last_beat) begin
            r_crc <= crc32_byte(r_crc, w_byte);
            if (w_data_end && !w_pad_need) begin
              r_state <= S_FCS;
              r_cnt   <= '0;
            end else begin
              if (w_data_end) begin
                r_state <= S_PAD;
              end
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_PAD: begin
          if (w_last_beat) begin
            r_crc <= crc32_byte(r_crc, w_byte);
            if (w_pad_end) begin
              r_state <= S_FCS;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_FCS: begin
          if (w_last_beat) begin
            if (r_cnt[1:0] == 2'd3) begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
              o_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
